// File: rtl/btn_step_conditioner.sv
// Button/switch input conditioner: two-flop synchronisers, debounce FSM and a
// one-cycle step pulse that carries the switch value captured at each press.
module btn_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       sw,
    output logic       step,
    output logic       w_out,
    output logic       btn_level,
    output logic [7:0] press_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_btn_meta;
    logic             r_btn_sync;
    logic             r_sw_meta;
    logic             r_sw_sync;
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_accept;
    logic             w_release;
    logic             r_step;
    logic             r_w_out;
    logic             r_btn_level;
    logic [7:0]       r_press_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_sw_meta  <= 1'b0;
            r_sw_sync  <= 1'b0;
        end else begin
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // The counter only advances while waiting, so it cannot pass CNT_LAST.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_btn_sync) begin
                    w_next_state = PRESS_WAIT;
                    w_next_cnt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_btn_sync) begin
                    w_next_state = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = HELD;
                    w_accept     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_btn_sync) begin
                    w_next_state = RELEASE_WAIT;
                    w_next_cnt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r_btn_sync) begin
                    w_next_state = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_state = IDLE;
                    w_release    = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Everything that accompanies an accepted press is registered on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step        <= 1'b0;
            r_w_out       <= 1'b0;
            r_btn_level   <= 1'b0;
            r_press_count <= 8'd0;
        end else begin
            r_step <= w_accept;
            if (w_accept) begin
                r_w_out       <= r_sw_sync;
                r_btn_level   <= 1'b1;
                r_press_count <= r_press_count + 8'd1;
            end else if (w_release) begin
                r_btn_level <= 1'b0;
            end
        end
    end

    assign step        = r_step;
    assign w_out       = r_w_out;
    assign btn_level   = r_btn_level;
    assign press_count = r_press_count;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Self-checking bench for btn_step_conditioner: a scoreboard of expected
// presses is checked by a monitor whenever step fires, plus per-scenario checks.
module tb_btn_step_conditioner;

    localparam int DEB = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       btn   = 1'b0;
    logic       sw    = 1'b0;
    logic       step;
    logic       w_out;
    logic       btn_level;
    logic [7:0] press_count;
    logic [1:0] state_dbg;

    typedef struct packed {
        logic       w;
        logic [7:0] cnt;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    int         checks    = 0;
    int         errors    = 0;
    int         stepCount = 0;
    logic [7:0] expCount  = 8'd0;

    btn_step_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .sw         (sw),
        .step       (step),
        .w_out      (w_out),
        .btn_level  (btn_level),
        .press_count(press_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // Every step pulse must match the oldest press the bench has queued.
    always @(negedge clk) begin
        if (step === 1'b1) begin
            stepCount++;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_step: step=1 at %0t, no press expected", $time);
            end else begin
                monE = expQ.pop_front();
                checks++;
                if (w_out !== monE.w) begin
                    errors++;
                    $display("[TB] FAIL step_w_out: got %b expected %b", w_out, monE.w);
                end
                checks++;
                if (press_count !== monE.cnt) begin
                    errors++;
                    $display("[TB] FAIL step_press_count: got %0d expected %0d", press_count, monE.cnt);
                end
                checks++;
                if (btn_level !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL step_btn_level: got %b expected 1", btn_level);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushPress(input logic w);
        expCount = expCount + 8'd1;
        expQ.push_back('{w: w, cnt: expCount});
    endtask

    task automatic doPress(input logic w, input int hold, input int rel);
        sw = w;
        repeat (3) tick();
        pushPress(w);
        btn = 1'b1;
        repeat (hold) tick();
        btn = 1'b0;
        repeat (rel) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({step, w_out, btn_level, press_count, state_dbg} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got step=%b w=%b lvl=%b cnt=%0d st=%0d expected all 0",
                     step, w_out, btn_level, press_count, state_dbg);
        end
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_clean_press();
        sw = 1'b1;
        repeat (3) tick();
        pushPress(1'b1);
        btn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (step !== (e == 7)) begin
                errors++;
                $display("[TB] FAIL press_latency: edge %0d step=%b expected %b", e, step, (e == 7));
            end
        end
        repeat (12) tick();
        checks++;
        if ({w_out, btn_level, press_count, state_dbg} !== {1'b1, 1'b1, 8'd1, 2'd2}) begin
            errors++;
            $display("[TB] FAIL press_hold: got w=%b lvl=%b cnt=%0d st=%0d expected w=1 lvl=1 cnt=1 st=2",
                     w_out, btn_level, press_count, state_dbg);
        end
        btn = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (btn_level !== (e < 7)) begin
                errors++;
                $display("[TB] FAIL release_latency: edge %0d btn_level=%b expected %b", e, btn_level, (e < 7));
            end
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("[TB] FAIL release_state: got %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            btn = 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (i == 3) btn = 1'b0;
                tick();
                checks++;
                if (state_dbg > 2'd1) begin
                    errors++;
                    $display("[TB] FAIL bounce_state: got %0d expected 0 or 1", state_dbg);
                end
            end
        end
        repeat (6) tick();
        checks++;
        if ({press_count, btn_level, state_dbg} !== {expCount, 1'b0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL bounce_final: got cnt=%0d lvl=%b st=%0d expected cnt=%0d lvl=0 st=0",
                     press_count, btn_level, state_dbg, expCount);
        end
    endtask

    task automatic test_switch_capture();
        sw = 1'b0;
        repeat (3) tick();
        pushPress(1'b0);
        btn = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) btn = 1'b0;
            sw = ~sw;
            tick();
            checks++;
            if (w_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL w_out_hold: cycle %0d got %b expected 0", i, w_out);
            end
        end
        doPress(1'b1, 10, 10);
        checks++;
        if ({w_out, press_count} !== {1'b1, expCount}) begin
            errors++;
            $display("[TB] FAIL second_capture: got w=%b cnt=%0d expected w=1 cnt=%0d",
                     w_out, press_count, expCount);
        end
    endtask

    task automatic test_release_debounce();
        logic saw3;
        saw3 = 1'b0;
        sw = 1'b1;
        repeat (3) tick();
        pushPress(1'b1);
        btn = 1'b1;
        repeat (10) tick();
        btn = 1'b0;
        repeat (2) tick();
        btn = 1'b1;
        repeat (8) begin
            tick();
            if (state_dbg == 2'd3) saw3 = 1'b1;
        end
        checks++;
        if ({saw3, state_dbg, btn_level} !== {1'b1, 2'd2, 1'b1}) begin
            errors++;
            $display("[TB] FAIL release_glitch: saw3=%b st=%0d lvl=%b expected saw3=1 st=2 lvl=1",
                     saw3, state_dbg, btn_level);
        end
        btn = 1'b0;
        repeat (10) tick();
        checks++;
        if ({btn_level, state_dbg} !== {1'b0, 2'd0}) begin
            errors++;
            $display("[TB] FAIL full_release: got lvl=%b st=%0d expected lvl=0 st=0", btn_level, state_dbg);
        end
    endtask

    task automatic test_wrap();
        int startSteps;
        startSteps = stepCount;
        for (int i = 0; i < 256; i++) begin
            doPress(logic'(i % 2), 9, 9);
        end
        checks++;
        if (stepCount - startSteps !== 256) begin
            errors++;
            $display("[TB] FAIL wrap_steps: got %0d expected 256", stepCount - startSteps);
        end
        checks++;
        if (press_count !== expCount) begin
            errors++;
            $display("[TB] FAIL wrap_count: got %0d expected %0d", press_count, expCount);
        end
    endtask

    task automatic test_async_reset();
        sw = 1'b1;
        repeat (3) tick();
        btn = 1'b1;
        repeat (5) tick();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({step, w_out, btn_level, press_count, state_dbg} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_press_wait: got step=%b w=%b lvl=%b cnt=%0d st=%0d expected all 0",
                     step, w_out, btn_level, press_count, state_dbg);
        end
        expCount = 8'd0;
        repeat (3) tick();
        reset = 1'b1;
        pushPress(1'b1);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (step !== (e == 7)) begin
                errors++;
                $display("[TB] FAIL held_through_reset: edge %0d step=%b expected %b", e, step, (e == 7));
            end
        end
        btn = 1'b0;
        repeat (10) tick();
        btn = 1'b1;
        repeat (7) tick();
        checks++;
        if ({step, press_count} !== {1'b1, 8'd2}) begin
            errors++;
            $display("[TB] FAIL pre_reset_step: got step=%b cnt=%0d expected step=1 cnt=2", step, press_count);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({step, w_out, btn_level, press_count, state_dbg} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_on_step: got step=%b w=%b lvl=%b cnt=%0d st=%0d expected all 0",
                     step, w_out, btn_level, press_count, state_dbg);
        end
        expCount = 8'd0;
        repeat (3) tick();
        reset = 1'b1;
        pushPress(1'b1);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (step !== (e == 7)) begin
                errors++;
                $display("[TB] FAIL step_after_reset: edge %0d step=%b expected %b", e, step, (e == 7));
            end
        end
        btn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_switch_capture();
        test_release_debounce();
        test_wrap();
        test_async_reset();
        checks++;
        if (expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL missing_steps: %0d expected presses never produced a step", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
